bsg_dfi_clk_gate_ctrl: RTL and testbench
========================================

// Module: bsg_dfi_clk_gate_ctrl
//
// PURPOSE
// Recovery sequencer for the DFI-to-AXI user clock gate, running in the AXI clock domain.
// When the AXI-side FIFO reports an error, it gates the user clock aligned to a DFI raw-clock edge.
// It then drains the FIFO and holds the user logic in reset for a fixed window.
// Finally it releases the gate on a later DFI edge.
// It replaces the free-running level gate with a sequenced, counted and observable recovery.
//
// PARAMETERS
// reset_cycles_p    16    cycles user_reset_o is held in RST; legal range >= 1
// drain_timeout_p   1024  maximum DRAIN cycles before forced exit; used only with the macro
// err_cnt_width_p   8     width of the saturating recovery counter
//
// PORTS
// clk_i           in   1                AXI clock
// reset_n_i       in   1                synchronous, active-low reset
// fifo_error_i    in   1                FIFO error level; sampled only in IDLE
// dfi_edge_i      in   1                single-cycle pulse, DFI raw-clock edge, already synchronized to clk_i
// fifo_empty_i    in   1                AXI FIFO empty
// sw_clear_i      in   1                clears err_count_o and timeout_o
// user_clk_gate_o out  1                1 = user clock gated
// fifo_flush_o    out  1                1 = drain the FIFO
// user_reset_o    out  1                1 = hold user logic in reset
// busy_o          out  1                1 = state != IDLE
// err_count_o     out  err_cnt_width_p  number of recoveries started; saturates
// timeout_o       out  1                sticky drain-timeout flag
//
// BEHAVIOUR
// - States: IDLE, ARM, DRAIN, RST, REL.
// - Outputs are a pure decode of the state register, so each output changes 1 cycle after its causing input is sampled.
// - Exceptions: err_count_o and timeout_o are separate registers.
// - Reset (reset_n_i = 0 at a clk_i edge), from any state:
//   - state goes to IDLE;
//   - every output goes to 0, including err_count_o and timeout_o;
//   - all counters go to 0;
//   - this applies mid-sequence as well; no partial recovery is resumed.
// - IDLE: if fifo_error_i = 1, go to ARM and increment err_count_o (saturating at all-ones).
// - ARM: wait for dfi_edge_i = 1, then go to DRAIN.
//   - A dfi_edge_i in the same cycle as the IDLE->ARM transition is not consumed.
// - DRAIN: when fifo_empty_i = 1, go to RST.
//   - If the FIFO is already empty, DRAIN lasts exactly 1 cycle.
// - RST: count from 0 to reset_cycles_p-1, then go to REL.
//   - user_reset_o is high for exactly reset_cycles_p cycles.
// - REL: wait for dfi_edge_i = 1, then go to IDLE.
// - Output decode:
//   - user_clk_gate_o = 1 in DRAIN, RST, REL;
//   - fifo_flush_o = 1 in DRAIN only;
//   - user_reset_o = 1 in RST only.
// - fifo_error_i is ignored outside IDLE.
//   - If it is still high on return to IDLE, ARM is re-entered on the next cycle and the count increments again.
// - sw_clear_i = 1 clears err_count_o and timeout_o.
//   - Clear wins over a same-cycle increment or set; the result is 0.
// - Counter widths are $clog2(limit+1).
// - The state counter is reused between DRAIN and RST and zeroed on each state entry.
//
// CONFIGURATION
// Macro: BSG_DFI_CLK_GATE_CTRL_TIMEOUT_EN
// - Defined:
//   - DRAIN counts its cycles.
//   - After drain_timeout_p cycles without fifo_empty_i, go to RST and set timeout_o.
//   - timeout_o stays set until sw_clear_i or reset.
//   - If fifo_empty_i and the timeout occur in the same cycle, it is a normal exit and timeout_o is not set.
// - Undefined:
//   - DRAIN waits indefinitely.
//   - timeout_o is tied to 0.
//   - No timeout counter logic is built.
//
// TESTING
// 1. Single recovery. Stimulus: fifo_error_i pulse at cycle 0; dfi_edge_i at cycles 3 and 40; fifo_empty_i = 1.
//    Required response: busy_o rises at cycle 1; gate and flush rise at cycle 4; flush falls at cycle 5;
//    user_reset_o high cycles 5-20; gate falls at cycle 41; err_count_o = 1.
// 2. Slow drain. Stimulus: fifo_empty_i = 0 for 50 DRAIN cycles.
//    Required response: fifo_flush_o high for 50 cycles, then RST; timeout_o = 0.
// 3. Drain timeout. Stimulus: macro defined, drain_timeout_p = 8, fifo_empty_i stuck at 0.
//    Required response: RST entered after 8 DRAIN cycles; timeout_o = 1 until sw_clear_i; then err_count_o = 0.
// 4. Saturation. Stimulus: err_cnt_width_p = 2, 5 full recoveries.
//    Required response: err_count_o = 3, with no wrap.
// 5. Reset mid-sequence. Stimulus: reset_n_i = 0 for 1 cycle during RST.
//    Required response: all outputs 0 on the next cycle; no REL; IDLE waits for fifo_error_i.
// 6. Persistent error. Stimulus: fifo_error_i held high.
//    Required response: back-to-back recoveries with exactly 1 IDLE cycle between them; one increment per recovery.

Source files
------------

// File: rtl/bsg_dfi_clk_gate_ctrl_if.sv
// Handshake and status bundle between the AXI-side FIFO and the DFI user clock gate sequencer.
// The master side drives FIFO status and software controls. The slave side is the sequencer.
interface bsg_dfi_clk_gate_ctrl_if #(
  parameter int unsigned err_cnt_width_p = 8
);
  logic                       fifo_error;
  logic                       dfi_edge;
  logic                       fifo_empty;
  logic                       sw_clear;
  logic                       user_clk_gate;
  logic                       fifo_flush;
  logic                       user_reset;
  logic                       busy;
  logic [err_cnt_width_p-1:0] err_count;
  logic                       timeout;

  modport master (
    output fifo_error, dfi_edge, fifo_empty, sw_clear,
    input  user_clk_gate, fifo_flush, user_reset, busy, err_count, timeout
  );

  modport slave (
    input  fifo_error, dfi_edge, fifo_empty, sw_clear,
    output user_clk_gate, fifo_flush, user_reset, busy, err_count, timeout
  );
endinterface

// File: rtl/bsg_dfi_clk_gate_ctrl.sv
// Recovery sequencer for the DFI-to-AXI user clock gate (AXI clock domain).
// Optional DRAIN timeout enabled by defining BSG_DFI_CLK_GATE_CTRL_TIMEOUT_EN.
module bsg_dfi_clk_gate_ctrl #(
  parameter int unsigned reset_cycles_p  = 16,
  parameter int unsigned drain_timeout_p = 1024,
  parameter int unsigned err_cnt_width_p = 8
) (
  input logic                         clk_i,
  input logic                         reset_n_i,
  bsg_dfi_clk_gate_ctrl_if.slave      ctrl
);

`ifdef BSG_DFI_CLK_GATE_CTRL_TIMEOUT_EN
  localparam int unsigned cnt_limit_lp =
      (reset_cycles_p > drain_timeout_p) ? reset_cycles_p : drain_timeout_p;
`else
  localparam int unsigned cnt_limit_lp = reset_cycles_p;
`endif
  localparam int unsigned cnt_width_lp = $clog2(cnt_limit_lp + 1);

  if (reset_cycles_p < 1) begin : g_bad_reset_cycles
    $error("reset_cycles_p must be at least 1");
  end
  if (drain_timeout_p < 1) begin : g_bad_drain_timeout
    $error("drain_timeout_p must be at least 1");
  end

  typedef enum logic [2:0] {StIdle, StArm, StDrain, StRst, StRel} state_e;

  state_e                     state_q, state_d;
  logic [cnt_width_lp-1:0]    cnt_q, cnt_d;
  logic [err_cnt_width_p-1:0] err_q, err_d;
  logic                       start;
`ifdef BSG_DFI_CLK_GATE_CTRL_TIMEOUT_EN
  logic                       timeout_q, timeout_d;
  logic                       timeout_set;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
`ifdef BSG_DFI_CLK_GATE_CTRL_TIMEOUT_EN
    timeout_set = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (ctrl.fifo_error) begin
          state_d = StArm;
          start   = 1'b1;
        end
      end
      StArm: begin
        if (ctrl.dfi_edge) begin
          state_d = StDrain;
          cnt_d   = '0;
        end
      end
      StDrain: begin
`ifdef BSG_DFI_CLK_GATE_CTRL_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        // An empty FIFO wins over a same-cycle timeout: normal exit, flag untouched
        if (ctrl.fifo_empty) begin
          state_d = StRst;
          cnt_d   = '0;
        end
`ifdef BSG_DFI_CLK_GATE_CTRL_TIMEOUT_EN
        else if (cnt_q == cnt_width_lp'(drain_timeout_p - 1)) begin
          state_d     = StRst;
          cnt_d       = '0;
          timeout_set = 1'b1;
        end
`endif
      end
      StRst: begin
        if (cnt_q == cnt_width_lp'(reset_cycles_p - 1)) begin
          state_d = StRel;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRel: begin
        if (ctrl.dfi_edge) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (start && (err_q != '1)) begin
      err_d = err_q + 1'b1;
    end
    if (ctrl.sw_clear) begin
      err_d = '0;
    end
  end

`ifdef BSG_DFI_CLK_GATE_CTRL_TIMEOUT_EN
  always_comb begin
    timeout_d = timeout_q | timeout_set;
    if (ctrl.sw_clear) begin
      timeout_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef BSG_DFI_CLK_GATE_CTRL_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign ctrl.timeout = timeout_q;
`else
  assign ctrl.timeout = 1'b0;
`endif

  assign ctrl.busy          = (state_q != StIdle);
  assign ctrl.user_clk_gate = (state_q == StDrain) || (state_q == StRst) || (state_q == StRel);
  assign ctrl.fifo_flush    = (state_q == StDrain);
  assign ctrl.user_reset    = (state_q == StRst);
  assign ctrl.err_count     = err_q;

endmodule

// File: tb/tb_bsg_dfi_clk_gate_ctrl.sv
// Self-checking bench for bsg_dfi_clk_gate_ctrl: vector table, corner sequences, random vs model.
module tb_bsg_dfi_clk_gate_ctrl;
  localparam int unsigned RstCycles = 16;
  localparam int unsigned DrainTo   = 8;
  localparam int unsigned ErrW      = 2;
  localparam int          ErrMax    = (1 << ErrW) - 1;
`ifdef BSG_DFI_CLK_GATE_CTRL_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  bsg_dfi_clk_gate_ctrl_if #(.err_cnt_width_p(ErrW)) bus ();

  bsg_dfi_clk_gate_ctrl #(
    .reset_cycles_p (RstCycles),
    .drain_timeout_p(DrainTo),
    .err_cnt_width_p(ErrW)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .ctrl     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0..4 = idle, waiting edge, draining, in reset, waiting release edge
  int ph = 0, rst_left = 0, drain_age = 0, m_err = 0;
  bit m_to = 1'b0;

  function automatic void model_step();
    int nerr;
    bit nto;
    if (!reset_n) begin
      ph = 0; m_err = 0; m_to = 1'b0; rst_left = 0; drain_age = 0;
      return;
    end
    nerr = m_err;
    nto  = m_to;
    case (ph)
      0: if (bus.fifo_error) begin ph = 1; if (m_err < ErrMax) nerr = m_err + 1; end
      1: if (bus.dfi_edge) begin ph = 2; drain_age = 0; end
      2: begin
        drain_age++;
        if (bus.fifo_empty) begin ph = 3; rst_left = RstCycles; end
        else if (ToEn && drain_age == DrainTo) begin ph = 3; rst_left = RstCycles; nto = 1'b1; end
      end
      3: begin rst_left--; if (rst_left == 0) ph = 4; end
      default: if (bus.dfi_edge) ph = 0;
    endcase
    if (bus.sw_clear) begin nerr = 0; nto = 1'b0; end
    m_err = nerr;
    m_to  = nto;
  endfunction

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic tick(input string name);
    logic [5+ErrW-1:0] got, exp;
    @(posedge clk);
    model_step();
    #1;
    got = {bus.busy, bus.user_clk_gate, bus.fifo_flush, bus.user_reset, bus.timeout,
           bus.err_count};
    exp = {ph != 0, ph >= 2, ph == 2, ph == 3, m_to, ErrW'(m_err)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got busy/gate/flush/rst/to/cnt=%b expected=%b at %0t", name, got, exp,
               $time);
    end
  endtask

  task automatic set_in(input logic e, input logic d, input logic m, input logic c,
                        input logic r);
    bus.fifo_error = e; bus.dfi_edge = d; bus.fifo_empty = m; bus.sw_clear = c; reset_n = r;
  endtask

  task automatic do_reset();
    set_in(0, 0, 1, 0, 0);
    tick("reset");
    tick("reset");
    reset_n = 1'b1;
  endtask

  task automatic recovery();
    bit done = 1'b0;
    bus.fifo_error = 1'b1; tick("rec_arm"); bus.fifo_error = 1'b0;
    bus.dfi_edge = 1'b1;   tick("rec_drain"); bus.dfi_edge = 1'b0;
    bus.fifo_empty = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      tick("rec_run");
      done = bus.user_clk_gate && !bus.fifo_flush && !bus.user_reset;
    end
    check_val("rec_reach_rel", int'(done), 1);
    bus.dfi_edge = 1'b1; tick("rec_release"); bus.dfi_edge = 1'b0;
  endtask

  typedef struct {
    int         rep;
    logic       err_in, edge_in, empty_in, clr_in, rstn_in;
    logic [3:0] exp_o;  // busy, gate, flush, user_reset
    int         exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int rep, input logic e, input logic d, input logic m, input logic c,
                     input logic r, input logic [3:0] o, input int cnt);
    vec_t v;
    v.rep = rep; v.err_in = e; v.edge_in = d; v.empty_in = m; v.clr_in = c; v.rstn_in = r;
    v.exp_o = o; v.exp_cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    int n, rises, zero_run;
    bit prev_busy, done;

    // Single recovery timeline, then same-cycle edge, short drain and mid-RST reset
    add(2,  0, 0, 1, 0, 0, 4'b0000, 0);
    add(1,  1, 0, 1, 0, 1, 4'b1000, 1);
    add(2,  0, 0, 1, 0, 1, 4'b1000, 1);
    add(1,  0, 1, 1, 0, 1, 4'b1110, 1);
    add(1,  0, 0, 1, 0, 1, 4'b1101, 1);
    add(15, 0, 0, 1, 0, 1, 4'b1101, 1);
    add(1,  0, 0, 1, 0, 1, 4'b1100, 1);
    add(19, 0, 0, 1, 0, 1, 4'b1100, 1);
    add(1,  0, 1, 1, 0, 1, 4'b0000, 1);
    add(1,  0, 0, 1, 1, 1, 4'b0000, 0);
    add(1,  1, 1, 1, 0, 1, 4'b1000, 1);
    add(3,  0, 0, 0, 0, 1, 4'b1000, 1);
    add(1,  0, 1, 0, 0, 1, 4'b1110, 1);
    add(3,  0, 0, 0, 0, 1, 4'b1110, 1);
    add(1,  0, 0, 1, 0, 1, 4'b1101, 1);
    add(4,  0, 0, 1, 0, 1, 4'b1101, 1);
    add(1,  0, 0, 1, 0, 0, 4'b0000, 0);
    add(3,  0, 1, 1, 0, 1, 4'b0000, 0);

    foreach (vecs[k]) begin
      for (int r = 0; r < vecs[k].rep; r++) begin
        set_in(vecs[k].err_in, vecs[k].edge_in, vecs[k].empty_in, vecs[k].clr_in,
               vecs[k].rstn_in);
        tick("vec_model");
        check_val($sformatf("vec%0d_outs", k),
                  int'({bus.busy, bus.user_clk_gate, bus.fifo_flush, bus.user_reset}),
                  int'(vecs[k].exp_o));
        check_val($sformatf("vec%0d_cnt", k), int'(bus.err_count), vecs[k].exp_cnt);
      end
    end

    // Slow drain: empty arrives on the 50th DRAIN cycle
    set_in(1, 0, 0, 0, 1); tick("slow_arm"); bus.fifo_error = 1'b0;
    bus.dfi_edge = 1'b1; tick("slow_drain"); bus.dfi_edge = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && bus.fifo_flush; i++) begin
      n++;
      if (n == 50) bus.fifo_empty = 1'b1;
      tick("slow_run");
    end
    check_val("slow_drain_len", n, ToEn ? int'(DrainTo) : 50);
    check_val("slow_drain_rst", int'(bus.user_reset), 1);
    check_val("slow_drain_timeout", int'(bus.timeout), int'(ToEn));
    bus.fifo_empty = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin tick("slow_rst"); done = !bus.user_reset; end
    check_val("slow_reach_rel", int'(done), 1);
    bus.dfi_edge = 1'b1; tick("slow_rel"); bus.dfi_edge = 1'b0;
    bus.sw_clear = 1'b1; tick("clear"); bus.sw_clear = 1'b0;
    check_val("clear_cnt", int'(bus.err_count), 0);
    check_val("clear_timeout", int'(bus.timeout), 0);

    // Clear beats a same-cycle increment
    set_in(1, 0, 1, 1, 1); tick("clr_vs_inc");
    check_val("clr_vs_inc_cnt", int'(bus.err_count), 0);
    check_val("clr_vs_inc_busy", int'(bus.busy), 1);
    set_in(0, 1, 1, 0, 1); tick("clr_drain"); bus.dfi_edge = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin tick("clr_run"); done = !bus.user_reset; end
    bus.dfi_edge = 1'b1; tick("clr_rel"); bus.dfi_edge = 1'b0;

    // Saturation after five recoveries
    for (int i = 0; i < 5; i++) recovery();
    check_val("saturate_cnt", int'(bus.err_count), ErrMax);
    check_val("saturate_idle", int'(bus.busy), 0);

    // Persistent error: one IDLE cycle between back-to-back recoveries
    bus.sw_clear = 1'b1; tick("persist_clear"); bus.sw_clear = 1'b0;
    set_in(1, 1, 1, 0, 1);
    rises = 0; zero_run = 0; prev_busy = 1'b0;
    for (int i = 0; i < 90; i++) begin
      tick("persist_run");
      if (bus.busy && !prev_busy) begin
        rises++;
        if (rises > 1) check_val("persist_gap", zero_run, 1);
        check_val("persist_cnt", int'(bus.err_count), (rises < ErrMax) ? rises : ErrMax);
        zero_run = 0;
      end
      if (!bus.busy) zero_run++;
      prev_busy = bus.busy;
    end
    check_val("persist_rises", int'(rises >= 4), 1);
    bus.fifo_error = 1'b0;
    for (int i = 0; i < 40 && bus.busy; i++) tick("persist_drain");

    // Random stimulus against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 2) != 0), ($urandom_range(0, 49) == 0),
             ($urandom_range(0, 199) != 0));
      tick("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
